uart_tx_fifo: RTL and testbench

//   UART transmitter with an input byte FIFO. Host pushes bytes with a one-cycle strobe.

---
 rtl/uart_tx_fifo_if.sv | 37 +++
 rtl/uart_tx_fifo.sv | 191 +++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Host-side byte channel and line outputs of the UART transmitter.
// Master = host (drives write strobe and byte), slave = transmitter.
// Carries FIFO status, serial line and event pulses back to the host.
interface uart_tx_fifo_if #(
  parameter int FIFO_DEPTH_LOG2 = 4
);
  logic                     i_Tx_DV;
  logic [7:0]               i_Tx_Byte;
  logic                     o_Tx_Ready;
  logic                     o_Tx_Serial;
  logic                     o_Tx_Active;
  logic                     o_Tx_Done;
  logic                     o_Overflow;
  logic [FIFO_DEPTH_LOG2:0] o_Fifo_Count;

  modport master (
    output i_Tx_DV,
    output i_Tx_Byte,
    input  o_Tx_Ready,
    input  o_Tx_Serial,
    input  o_Tx_Active,
    input  o_Tx_Done,
    input  o_Overflow,
    input  o_Fifo_Count
  );

  modport slave (
    input  i_Tx_DV,
    input  i_Tx_Byte,
    output o_Tx_Ready,
    output o_Tx_Serial,
    output o_Tx_Active,
    output o_Tx_Done,
    output o_Overflow,
    output o_Fifo_Count
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a circular byte FIFO; frames stream back-to-back.
// Latency: write at edge N -> start bit on the line after edge N+2; frame = 10*CLKS_PER_BIT cycles.
// Backpressure: o_Tx_Ready drops when the FIFO is full; writes while not ready are dropped with o_Overflow.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT    = 218,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic           i_Clock,
  input  logic           i_Rst_n,
  uart_tx_fifo_if.slave  bus
);

  localparam int AW    = FIFO_DEPTH_LOG2;
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int CW    = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_PRE  = CW'(CLKS_PER_BIT - 2);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;
  logic          ready_q;
  logic          pend_q;
  logic          fifo_push;
  logic          fifo_pop;
  logic [7:0]    head_byte;

  // Serialiser state
  state_t        state_q;
  logic [CW-1:0] clk_cnt_q;
  logic [2:0]    bit_idx_q;
  logic [2:0]    nxt_idx;
  logic [7:0]    shift_q;
  logic          serial_q;
  logic          active_q;
  logic          done_q;
  logic          bit_last;

  assign bit_last  = (clk_cnt_q == BIT_LAST);
  assign nxt_idx   = bit_idx_q + 3'd1;
  assign head_byte = mem_q[rd_ptr_q];

  // Acceptance is judged against the registered ready flag only, so a pop in
  // the same cycle never rescues a write that arrived while the FIFO was full.
  assign fifo_push = bus.i_Tx_DV && ready_q;

  // The idle launch waits on pend_q (count seen non-zero one cycle earlier);
  // that extra cycle fixes write-to-start-bit latency at two edges.
  // At the end of a stop bit the next byte is taken at once, with no gap.
  assign fifo_pop = (count_q != '0) &&
                    (((state_q == IDLE) && pend_q) ||
                     ((state_q == STOP) && bit_last));

  // Next occupancy: simultaneous push and pop leave the count unchanged
  always_comb begin
    count_d = count_q;
    if (fifo_push && !fifo_pop) begin
      count_d = count_q + CNT_ONE;
    end else if (fifo_pop && !fifo_push) begin
      count_d = count_q - CNT_ONE;
    end
  end

  // Byte storage; contents need no reset since the pointers define validity
  always_ff @(posedge i_Clock) begin
    if (fifo_push) begin
      mem_q[wr_ptr_q] <= bus.i_Tx_Byte;
    end
  end

  // FIFO pointers, occupancy, registered ready and launch-pending flag
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
      pend_q   <= 1'b0;
    end else begin
      if (fifo_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (fifo_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      count_q <= count_d;
      ready_q <= (count_d != FULL_CNT);
      pend_q  <= (count_q != '0);
    end
  end

  // Frame FSM: line, active and done are registered alongside the state
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      serial_q  <= 1'b1;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // Done lands on the final cycle of the stop bit
      done_q <= (state_q == STOP) && (clk_cnt_q == BIT_PRE);

      case (state_q)
        IDLE: begin
          clk_cnt_q <= '0;
          bit_idx_q <= '0;
          serial_q  <= 1'b1;
          if (fifo_pop) begin
            shift_q  <= head_byte;
            state_q  <= START;
            serial_q <= 1'b0;
            active_q <= 1'b1;
          end
        end

        START: begin
          if (bit_last) begin
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            state_q   <= DATA;
            serial_q  <= shift_q[0];
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end

        DATA: begin
          if (bit_last) begin
            clk_cnt_q <= '0;
            bit_idx_q <= nxt_idx;
            if (bit_idx_q == 3'd7) begin
              state_q  <= STOP;
              serial_q <= 1'b1;
            end else begin
              serial_q <= shift_q[nxt_idx];
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end

        STOP: begin
          if (bit_last) begin
            clk_cnt_q <= '0;
            if (fifo_pop) begin
              shift_q  <= head_byte;
              state_q  <= START;
              serial_q <= 1'b0;
            end else begin
              state_q  <= IDLE;
              active_q <= 1'b0;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end

        default: begin
          state_q  <= IDLE;
          serial_q <= 1'b1;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_Tx_Ready   = ready_q;
  assign bus.o_Tx_Serial  = serial_q;
  assign bus.o_Tx_Active  = active_q;
  assign bus.o_Tx_Done    = done_q;
  assign bus.o_Overflow   = bus.i_Tx_DV && !ready_q;
  assign bus.o_Fifo_Count = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a fast instance (4 clocks/bit, depth 4)
// for cycle-exact checks, and a 218 clocks/bit instance feeding a serial
// receiver model for the loopback check.
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  uart_tx_fifo_if #(.FIFO_DEPTH_LOG2(2)) bus1 ();
  uart_tx_fifo_if #(.FIFO_DEPTH_LOG2(4)) bus2 ();

  uart_tx_fifo #(.CLKS_PER_BIT(4), .FIFO_DEPTH_LOG2(2)) dut1 (
    .i_Clock (clk),
    .i_Rst_n (rst_n),
    .bus     (bus1)
  );

  uart_tx_fifo #(.CLKS_PER_BIT(218), .FIFO_DEPTH_LOG2(4)) dut2 (
    .i_Clock (clk),
    .i_Rst_n (rst_n),
    .bus     (bus2)
  );

  // Serial receiver model on the slow instance: mid-bit sampling
  logic [7:0] rx_q [$];
  int         rx_frame_err = 0;

  initial begin : rx_model
    logic [7:0] b;
    forever begin
      @(negedge bus2.o_Tx_Serial);
      repeat (109) @(posedge clk);
      #1;
      if (bus2.o_Tx_Serial !== 1'b0) rx_frame_err++;
      for (int j = 0; j < 8; j++) begin
        repeat (218) @(posedge clk);
        #1;
        b[j] = bus2.o_Tx_Serial;
      end
      repeat (218) @(posedge clk);
      #1;
      if (bus2.o_Tx_Serial !== 1'b1) rx_frame_err++;
      rx_q.push_back(b);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus1.i_Tx_DV = 1'b0;
    bus1.i_Tx_Byte = 8'h00;
    bus2.i_Tx_DV = 1'b0;
    bus2.i_Tx_Byte = 8'h00;
    repeat (3) cyc();
    tests_run++;
    if ({bus1.o_Tx_Serial, bus1.o_Tx_Active, bus1.o_Tx_Done, bus1.o_Overflow,
         bus1.o_Tx_Ready, bus1.o_Fifo_Count} !== {5'b10001, 3'd0}) begin
      tests_failed++;
      $display("FAIL reset_state: got ser/act/done/ovf/rdy/cnt=%b/%b/%b/%b/%b/%0d expected 1/0/0/0/1/0",
               bus1.o_Tx_Serial, bus1.o_Tx_Active, bus1.o_Tx_Done, bus1.o_Overflow,
               bus1.o_Tx_Ready, bus1.o_Fifo_Count);
    end
    rst_n = 1'b1;
    cyc();
    tests_run++;
    if ({bus1.o_Tx_Serial, bus1.o_Tx_Active, bus1.o_Tx_Ready} !== 3'b101) begin
      tests_failed++;
      $display("FAIL reset_release: got ser/act/rdy=%b/%b/%b expected 1/0/1",
               bus1.o_Tx_Serial, bus1.o_Tx_Active, bus1.o_Tx_Ready);
    end
  endtask

  task automatic test_single();
    logic [9:0] frame;
    frame = {1'b1, 8'hA5, 1'b0};
    bus1.i_Tx_DV = 1'b1;
    bus1.i_Tx_Byte = 8'hA5;
    cyc();
    bus1.i_Tx_DV = 1'b0;
    bus1.i_Tx_Byte = 8'h3C;
    tests_run++;
    if ({bus1.o_Fifo_Count, bus1.o_Tx_Serial} !== {3'd1, 1'b1}) begin
      tests_failed++;
      $display("FAIL single_queued: got cnt=%0d ser=%b expected cnt=1 ser=1",
               bus1.o_Fifo_Count, bus1.o_Tx_Serial);
    end
    cyc();
    tests_run++;
    if ({bus1.o_Tx_Serial, bus1.o_Tx_Active} !== 2'b10) begin
      tests_failed++;
      $display("FAIL single_not_yet: got ser=%b act=%b expected 1/0",
               bus1.o_Tx_Serial, bus1.o_Tx_Active);
    end
    cyc();
    for (int k = 0; k < 40; k++) begin
      tests_run++;
      if ({bus1.o_Tx_Serial, bus1.o_Tx_Active, bus1.o_Tx_Done} !==
          {frame[k/4], 1'b1, (k == 39)}) begin
        tests_failed++;
        $display("FAIL single_frame cycle %0d: got ser/act/done=%b/%b/%b expected %b/1/%b",
                 k, bus1.o_Tx_Serial, bus1.o_Tx_Active, bus1.o_Tx_Done, frame[k/4], (k == 39));
      end
      cyc();
    end
    tests_run++;
    if ({bus1.o_Tx_Serial, bus1.o_Tx_Active, bus1.o_Tx_Done} !== 3'b100) begin
      tests_failed++;
      $display("FAIL single_after: got ser/act/done=%b/%b/%b expected 1/0/0",
               bus1.o_Tx_Serial, bus1.o_Tx_Active, bus1.o_Tx_Done);
    end
  endtask

  task automatic test_back_to_back();
    logic [29:0] stream;
    stream = {1'b1, 8'h55, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0};
    bus1.i_Tx_DV = 1'b1;
    bus1.i_Tx_Byte = 8'h00;
    cyc();
    tests_run++;
    if (bus1.o_Fifo_Count !== 3'd1) begin
      tests_failed++;
      $display("FAIL b2b_count1: got %0d expected 1", bus1.o_Fifo_Count);
    end
    bus1.i_Tx_Byte = 8'hFF;
    cyc();
    tests_run++;
    if (bus1.o_Fifo_Count !== 3'd2) begin
      tests_failed++;
      $display("FAIL b2b_count2: got %0d expected 2", bus1.o_Fifo_Count);
    end
    bus1.i_Tx_Byte = 8'h55;
    cyc();
    bus1.i_Tx_DV = 1'b0;
    tests_run++;
    if (bus1.o_Fifo_Count !== 3'd2) begin
      tests_failed++;
      $display("FAIL b2b_count3: got %0d expected 2", bus1.o_Fifo_Count);
    end
    for (int k = 0; k < 120; k++) begin
      tests_run++;
      if ({bus1.o_Tx_Serial, bus1.o_Tx_Active, bus1.o_Tx_Done} !==
          {stream[k/4], 1'b1, ((k % 40) == 39)}) begin
        tests_failed++;
        $display("FAIL b2b_stream cycle %0d: got ser/act/done=%b/%b/%b expected %b/1/%b",
                 k, bus1.o_Tx_Serial, bus1.o_Tx_Active, bus1.o_Tx_Done,
                 stream[k/4], ((k % 40) == 39));
      end
      cyc();
    end
    tests_run++;
    if ({bus1.o_Tx_Serial, bus1.o_Tx_Active, bus1.o_Fifo_Count} !== {2'b10, 3'd0}) begin
      tests_failed++;
      $display("FAIL b2b_drained: got ser/act/cnt=%b/%b/%0d expected 1/0/0",
               bus1.o_Tx_Serial, bus1.o_Tx_Active, bus1.o_Fifo_Count);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] d  [6];
    logic [7:0] rx [5];
    int dones;
    d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    rx = '{default: 8'h00};
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) begin
        tests_run++;
        if ({bus1.o_Tx_Ready, bus1.o_Fifo_Count} !== {1'b0, 3'd4}) begin
          tests_failed++;
          $display("FAIL ovf_full: got rdy=%b cnt=%0d expected rdy=0 cnt=4",
                   bus1.o_Tx_Ready, bus1.o_Fifo_Count);
        end
      end
      bus1.i_Tx_DV = 1'b1;
      bus1.i_Tx_Byte = d[i];
      #1;
      if (i == 5) begin
        tests_run++;
        if (bus1.o_Overflow !== 1'b1) begin
          tests_failed++;
          $display("FAIL ovf_pulse: got %b expected 1", bus1.o_Overflow);
        end
      end
      cyc();
    end
    bus1.i_Tx_DV = 1'b0;
    #1;
    tests_run++;
    if ({bus1.o_Overflow, bus1.o_Fifo_Count} !== {1'b0, 3'd4}) begin
      tests_failed++;
      $display("FAIL ovf_after: got ovf=%b cnt=%0d expected ovf=0 cnt=4",
               bus1.o_Overflow, bus1.o_Fifo_Count);
    end
    for (int k = 3; k < 260; k++) begin
      if (bus1.o_Tx_Done === 1'b1) dones++;
      if ((k % 4) == 2 && (k / 40) < 5 && ((k % 40) / 4) >= 1 && ((k % 40) / 4) <= 8)
        rx[k / 40][((k % 40) / 4) - 1] = bus1.o_Tx_Serial;
      cyc();
    end
    tests_run++;
    if (dones != 5) begin
      tests_failed++;
      $display("FAIL ovf_frames: got %0d done pulses expected 5", dones);
    end
    for (int f = 0; f < 5; f++) begin
      tests_run++;
      if (rx[f] !== d[f]) begin
        tests_failed++;
        $display("FAIL ovf_byte%0d: got %02h expected %02h", f, rx[f], d[f]);
      end
    end
    tests_run++;
    if ({bus1.o_Tx_Active, bus1.o_Fifo_Count} !== {1'b0, 3'd0}) begin
      tests_failed++;
      $display("FAIL ovf_idle: got act=%b cnt=%0d expected 0/0",
               bus1.o_Tx_Active, bus1.o_Fifo_Count);
    end
  endtask

  task automatic test_full_pop();
    bit found;
    int dones;
    found = 1'b0;
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      bus1.i_Tx_DV = 1'b1;
      bus1.i_Tx_Byte = 8'(8'h21 + i);
      cyc();
    end
    bus1.i_Tx_DV = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (bus1.o_Tx_Done === 1'b1) begin
        found = 1'b1;
        break;
      end
      cyc();
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL fullpop_wait: got no done pulse within 100 cycles expected one");
    end
    bus1.i_Tx_DV = 1'b1;
    bus1.i_Tx_Byte = 8'h99;
    #1;
    tests_run++;
    if ({bus1.o_Overflow, bus1.o_Tx_Ready, bus1.o_Fifo_Count} !== {2'b10, 3'd4}) begin
      tests_failed++;
      $display("FAIL fullpop_reject: got ovf=%b rdy=%b cnt=%0d expected 1/0/4",
               bus1.o_Overflow, bus1.o_Tx_Ready, bus1.o_Fifo_Count);
    end
    cyc();
    bus1.i_Tx_DV = 1'b0;
    tests_run++;
    if ({bus1.o_Tx_Ready, bus1.o_Fifo_Count} !== {1'b1, 3'd3}) begin
      tests_failed++;
      $display("FAIL fullpop_next: got rdy=%b cnt=%0d expected rdy=1 cnt=3",
               bus1.o_Tx_Ready, bus1.o_Fifo_Count);
    end
    for (int n = 0; n < 200; n++) begin
      if (bus1.o_Tx_Done === 1'b1) dones++;
      cyc();
    end
    tests_run++;
    if ({dones, bus1.o_Tx_Active, bus1.o_Fifo_Count} !== {32'd4, 1'b0, 3'd0}) begin
      tests_failed++;
      $display("FAIL fullpop_drain: got dones=%0d act=%b cnt=%0d expected 4/0/0",
               dones, bus1.o_Tx_Active, bus1.o_Fifo_Count);
    end
  endtask

  task automatic test_reset_mid();
    bit activity;
    activity = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus1.i_Tx_DV = 1'b1;
      bus1.i_Tx_Byte = 8'(8'h11 * i);
      cyc();
    end
    bus1.i_Tx_DV = 1'b0;
    repeat (10) cyc();
    tests_run++;
    if ({bus1.o_Tx_Serial, bus1.o_Tx_Active} !== 2'b01) begin
      tests_failed++;
      $display("FAIL rstmid_in_data: got ser=%b act=%b expected 0/1",
               bus1.o_Tx_Serial, bus1.o_Tx_Active);
    end
    #1;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus1.o_Tx_Serial, bus1.o_Tx_Active, bus1.o_Tx_Ready, bus1.o_Fifo_Count} !==
        {3'b101, 3'd0}) begin
      tests_failed++;
      $display("FAIL rstmid_async: got ser/act/rdy/cnt=%b/%b/%b/%0d expected 1/0/1/0",
               bus1.o_Tx_Serial, bus1.o_Tx_Active, bus1.o_Tx_Ready, bus1.o_Fifo_Count);
    end
    #1;
    rst_n = 1'b1;
    for (int n = 0; n < 100; n++) begin
      cyc();
      if (bus1.o_Tx_Active !== 1'b0 || bus1.o_Tx_Done !== 1'b0 || bus1.o_Tx_Serial !== 1'b1)
        activity = 1'b1;
    end
    tests_run++;
    if ({activity, bus1.o_Fifo_Count} !== {1'b0, 3'd0}) begin
      tests_failed++;
      $display("FAIL rstmid_quiet: got activity=%b cnt=%0d expected 0/0",
               activity, bus1.o_Fifo_Count);
    end
  endtask

  task automatic test_loopback();
    logic [7:0] sent [$];
    logic [7:0] got;
    bit ovf_seen;
    int guard;
    ovf_seen = 1'b0;
    guard = 0;
    while (sent.size() < 16 && guard < 1000) begin
      if (bus2.o_Tx_Ready === 1'b1) begin
        bus2.i_Tx_DV = 1'b1;
        bus2.i_Tx_Byte = 8'($urandom_range(255, 0));
        sent.push_back(bus2.i_Tx_Byte);
      end else begin
        bus2.i_Tx_DV = 1'b0;
      end
      #1;
      if (bus2.o_Overflow === 1'b1) ovf_seen = 1'b1;
      cyc();
      guard++;
    end
    bus2.i_Tx_DV = 1'b0;
    guard = 0;
    while (rx_q.size() < 16 && guard < 40000) begin
      if (bus2.o_Overflow === 1'b1) ovf_seen = 1'b1;
      cyc();
      guard++;
    end
    tests_run++;
    if (rx_q.size() != 16) begin
      tests_failed++;
      $display("FAIL loop_count: got %0d bytes received expected 16", rx_q.size());
    end
    for (int i = 0; i < 16; i++) begin
      if (rx_q.size() == 0 || i >= sent.size()) break;
      got = rx_q.pop_front();
      tests_run++;
      if (got !== sent[i]) begin
        tests_failed++;
        $display("FAIL loop_byte%0d: got %02h expected %02h", i, got, sent[i]);
      end
    end
    tests_run++;
    if ({ovf_seen, (rx_frame_err != 0)} !== 2'b00) begin
      tests_failed++;
      $display("FAIL loop_errors: got overflow=%b framing_errors=%0d expected 0/0",
               ovf_seen, rx_frame_err);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_loopback();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
